sbox_layer_iter: RTL and testbench

SBOX_LAYER_ITER -- requirements
Module: sbox_layer_iter

---
 rtl/sbox_layer_iter.sv | 123 ++++++++++++
 tb/tb_sbox_layer_iter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_layer_iter.sv
// Iterative ASCON 5-bit S-box layer: substitutes NSBOX columns of the 320-bit
// state per cycle, forward or inverse, with valid/ready handshakes on both sides.
module sbox_layer_iter #(
  parameter int NSBOX  = 8,
  parameter bit INV_EN = 1'b1
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [319:0] state_i,
  input  logic         inv_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] state_o,
  output logic         busy_o
);

  localparam int NSTEP = 64 / NSBOX;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSTEP - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t              fsm_q;
  logic [CW-1:0]     cnt_q;
  logic [4:0][63:0]  st_q;
  logic [4:0][63:0]  st_nxt;
  logic              inv_q;
  logic [5:0]        col;
  logic [4:0]        cin;
  logic [4:0]        cout;

  function automatic logic [4:0] sbox_fwd(input logic [4:0] v);
    case (v)
      5'h00: return 5'h04;  5'h01: return 5'h0B;  5'h02: return 5'h1F;  5'h03: return 5'h14;
      5'h04: return 5'h1A;  5'h05: return 5'h15;  5'h06: return 5'h09;  5'h07: return 5'h02;
      5'h08: return 5'h1B;  5'h09: return 5'h05;  5'h0A: return 5'h08;  5'h0B: return 5'h12;
      5'h0C: return 5'h1D;  5'h0D: return 5'h03;  5'h0E: return 5'h06;  5'h0F: return 5'h1C;
      5'h10: return 5'h1E;  5'h11: return 5'h13;  5'h12: return 5'h07;  5'h13: return 5'h0E;
      5'h14: return 5'h00;  5'h15: return 5'h0D;  5'h16: return 5'h11;  5'h17: return 5'h18;
      5'h18: return 5'h10;  5'h19: return 5'h0C;  5'h1A: return 5'h01;  5'h1B: return 5'h19;
      5'h1C: return 5'h16;  5'h1D: return 5'h0A;  5'h1E: return 5'h0F;  default: return 5'h17;
    endcase
  endfunction

  function automatic logic [4:0] sbox_inv(input logic [4:0] v);
    case (v)
      5'h00: return 5'h14;  5'h01: return 5'h1A;  5'h02: return 5'h07;  5'h03: return 5'h0D;
      5'h04: return 5'h00;  5'h05: return 5'h09;  5'h06: return 5'h0E;  5'h07: return 5'h12;
      5'h08: return 5'h0A;  5'h09: return 5'h06;  5'h0A: return 5'h1D;  5'h0B: return 5'h01;
      5'h0C: return 5'h19;  5'h0D: return 5'h15;  5'h0E: return 5'h13;  5'h0F: return 5'h1E;
      5'h10: return 5'h18;  5'h11: return 5'h16;  5'h12: return 5'h0B;  5'h13: return 5'h11;
      5'h14: return 5'h03;  5'h15: return 5'h05;  5'h16: return 5'h1C;  5'h17: return 5'h1F;
      5'h18: return 5'h17;  5'h19: return 5'h1B;  5'h1A: return 5'h04;  5'h1B: return 5'h08;
      5'h1C: return 5'h0F;  5'h1D: return 5'h0C;  5'h1E: return 5'h10;  default: return 5'h02;
    endcase
  endfunction

  // Plane 4 is x0 (column MSB), plane 0 is x4; only the cnt-selected slice changes.
  always_comb begin
    st_nxt = st_q;
    col    = '0;
    cin    = '0;
    cout   = '0;
    for (int k = 0; k < NSBOX; k++) begin
      col  = 6'(int'(cnt_q) * NSBOX + k);
      cin  = {st_q[4][col], st_q[3][col], st_q[2][col], st_q[1][col], st_q[0][col]};
      cout = inv_q ? sbox_inv(cin) : sbox_fwd(cin);
      st_nxt[4][col] = cout[4];
      st_nxt[3][col] = cout[3];
      st_nxt[2][col] = cout[2];
      st_nxt[1][col] = cout[1];
      st_nxt[0][col] = cout[0];
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      inv_q       <= 1'b0;
      in_ready_o  <= 1'b1;
      busy_o      <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid_i) begin
            st_q       <= state_i;
            inv_q      <= INV_EN & inv_i;
            cnt_q      <= '0;
            fsm_q      <= RUN;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        RUN: begin
          st_q  <= st_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            fsm_q       <= DONE;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b1;
          end
        end
        DONE: begin
          // A pending input is not taken here; in_ready_o only rises back in IDLE.
          if (out_ready_i) begin
            fsm_q       <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state_o = st_q;

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Directed bench for sbox_layer_iter: four instances (NSBOX 64/4/1 and an
// INV_EN=0 variant) share one stimulus stream.
module tb_sbox_layer_iter;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic [319:0] st_in;
  logic         inv;
  logic         out_ready;
  logic         rdy [4];
  logic         ov  [4];
  logic         bsy [4];
  logic [319:0] so  [4];

  int compared = 0;
  int mism     = 0;
  int lat [4]  = '{1, 16, 64, 8};

  logic [4:0] fwd [32] = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                           5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                           5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                           5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
  logic [4:0] invt [32];

  always #5 clk = ~clk;

  sbox_layer_iter #(.NSBOX(64), .INV_EN(1'b1)) u0 (
    .clock_i(clk), .resetb_i(rstn), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
    .state_i(st_in), .inv_i(inv), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .state_o(so[0]), .busy_o(bsy[0]));
  sbox_layer_iter #(.NSBOX(4), .INV_EN(1'b1)) u1 (
    .clock_i(clk), .resetb_i(rstn), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
    .state_i(st_in), .inv_i(inv), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .state_o(so[1]), .busy_o(bsy[1]));
  sbox_layer_iter #(.NSBOX(1), .INV_EN(1'b1)) u2 (
    .clock_i(clk), .resetb_i(rstn), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
    .state_i(st_in), .inv_i(inv), .out_valid_o(ov[2]), .out_ready_i(out_ready),
    .state_o(so[2]), .busy_o(bsy[2]));
  sbox_layer_iter #(.NSBOX(8), .INV_EN(1'b0)) u3 (
    .clock_i(clk), .resetb_i(rstn), .in_valid_i(in_valid), .in_ready_o(rdy[3]),
    .state_i(st_in), .inv_i(inv), .out_valid_o(ov[3]), .out_ready_i(out_ready),
    .state_o(so[3]), .busy_o(bsy[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] model(input logic [319:0] s, input bit m);
    logic [4:0][63:0] p;
    logic [4:0][63:0] o;
    logic [4:0] c;
    logic [4:0] r;
    logic [5:0] jj;
    p = s;
    o = '0;
    for (int j = 0; j < 64; j++) begin
      jj = 6'(j);
      c  = {p[4][jj], p[3][jj], p[2][jj], p[1][jj], p[0][jj]};
      r  = m ? invt[c] : fwd[c];
      o[4][jj] = r[4];
      o[3][jj] = r[3];
      o[2][jj] = r[2];
      o[1][jj] = r[1];
      o[0][jj] = r[0];
    end
    return o;
  endfunction

  function automatic logic [319:0] splat(input logic [4:0] v);
    return {{64{v[4]}}, {64{v[3]}}, {64{v[2]}}, {64{v[1]}}, {64{v[0]}}};
  endfunction

  // Accept one state, scramble the inputs during RUN, check latency/busy/result, then drain.
  task automatic run_op(input logic [319:0] s, input bit m, input logic [319:0] e,
                        input logic [319:0] e3, input string tag);
    int  seen [4];
    int  busyc [4];
    bit  all;
    in_valid  = 1'b1;
    st_in     = s;
    inv       = m;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    inv      = ~m;
    st_in    = ~s;
    all      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen[i]  = -1;
      busyc[i] = bsy[i] ? 1 : 0;
    end
    for (int c = 1; c <= 100 && !all; c++) begin
      tick();
      all = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (seen[i] < 0 && ov[i] === 1'b1) seen[i] = c;
        if (bsy[i] === 1'b1) busyc[i]++;
        if (seen[i] < 0) all = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s latency u%0d", tag, i), 320'(seen[i]), 320'(lat[i]));
      chk($sformatf("%s busy_cycles u%0d", tag, i), 320'(busyc[i]), 320'(lat[i]));
      chk($sformatf("%s state u%0d", tag, i), so[i], (i == 3) ? e3 : e);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s ready_after u%0d", tag, i), {319'd0, rdy[i]}, 320'd1);
  endtask

  initial begin
    logic [319:0] r;
    logic [319:0] fr;
    logic [319:0] held [4];
    bit           stray;
    logic [4:0]   vv;

    for (int v = 0; v < 32; v++) begin
      vv = 5'(v);
      invt[fwd[vv]] = vv;
    end

    rstn = 1'b0; in_valid = 1'b0; st_in = '0; inv = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset ready u%0d", i), {319'd0, rdy[i]}, 320'd1);
      chk($sformatf("reset valid u%0d", i), {319'd0, ov[i]}, 320'd0);
      chk($sformatf("reset busy u%0d", i), {319'd0, bsy[i]}, 320'd0);
      chk($sformatf("reset state u%0d", i), so[i], 320'd0);
    end

    // Zero state: every column 00 -> 04, only x2 set.
    run_op(320'd0, 1'b0, {128'd0, {64{1'b1}}, 128'd0}, {128'd0, {64{1'b1}}, 128'd0}, "zero_fwd");
    // All ones: column 1F -> 17, only x1 clear.
    run_op({320{1'b1}}, 1'b0, {{64{1'b1}}, 64'd0, {192{1'b1}}},
           {{64{1'b1}}, 64'd0, {192{1'b1}}}, "ones_fwd");
    // Inverse of column 04 is 00; the INV_EN=0 instance applies forward 04 -> 1A.
    run_op({128'd0, {64{1'b1}}, 128'd0}, 1'b1, 320'd0,
           {{128{1'b1}}, 64'd0, {64{1'b1}}, 64'd0}, "x2_inv");

    r = '0;
    for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom)};
    fr = model(r, 1'b0);
    run_op(r, 1'b0, fr, fr, "rand_fwd");
    run_op(fr, 1'b1, r, model(fr, 1'b0), "rand_inv");

    for (int v = 0; v < 32; v++) begin
      vv = 5'(v);
      run_op(splat(vv), 1'b0, splat(fwd[vv]), splat(fwd[vv]), $sformatf("col_fwd_%02h", v));
      run_op(splat(vv), 1'b1, splat(invt[vv]), splat(fwd[vv]), $sformatf("col_inv_%02h", v));
    end

    // Backpressure: hold DONE with a competing input pending.
    in_valid = 1'b1; st_in = {320{1'b1}}; inv = 1'b0; out_ready = 1'b0;
    tick();
    st_in = r;
    repeat (70) tick();
    for (int i = 0; i < 4; i++) held[i] = so[i];
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("bp state c%0d u%0d", c, i), so[i], {{64{1'b1}}, 64'd0, {192{1'b1}}});
        chk($sformatf("bp hold c%0d u%0d", c, i), so[i], held[i]);
        chk($sformatf("bp ready c%0d u%0d", c, i), {319'd0, rdy[i]}, 320'd0);
        chk($sformatf("bp valid c%0d u%0d", c, i), {319'd0, ov[i]}, 320'd1);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp release ready u%0d", i), {319'd0, rdy[i]}, 320'd1);
      chk($sformatf("bp release busy u%0d", i), {319'd0, bsy[i]}, 320'd0);
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp next accept u%0d", i), {319'd0, bsy[i]}, 320'd1);
    repeat (70) tick();
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp next result u%0d", i), so[i], fr);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of the NSBOX=1 run, at cnt = 30.
    in_valid = 1'b1; st_in = r; inv = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (30) tick();
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort state u%0d", i), so[i], 320'd0);
      chk($sformatf("abort valid u%0d", i), {319'd0, ov[i]}, 320'd0);
      chk($sformatf("abort busy u%0d", i), {319'd0, bsy[i]}, 320'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 70; c++) begin
      tick();
      for (int i = 0; i < 4; i++) if (ov[i] !== 1'b0) stray = 1'b1;
    end
    chk("abort no_valid", {319'd0, stray}, 320'd0);
    run_op(r, 1'b0, fr, fr, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
